// File: rtl/snd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : snd_pkg
// Brief   : Shared types and constants for the sound command path
//           (transmitter FSM states, status byte bit positions, helpers).
// Revision: 1.0 - initial release
// ============================================================================
package snd_pkg;

    // Transmitter FSM states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        STROBE   = 3'd2,
        WAIT_SET = 3'd3,
        WAIT_CLR = 3'd4
    } snd_tx_st_t;

    // Status byte bit positions, shared with the sound-side status decode
    localparam int STAT_OVF     = 7;
    localparam int STAT_LOST    = 6;
    localparam int STAT_MS      = 5;
    localparam int STAT_BUSY    = 4;
    localparam int STAT_CNT_MSB = 2;
    localparam int STAT_CNT_LSB = 0;

    // Saturate a queue occupancy to the 3-bit status count field
    function automatic logic [2:0] sat3(input logic [31:0] n);
        return (n > 32'd7) ? 3'd7 : n[2:0];
    endfunction

endpackage : snd_pkg
`default_nettype wire

// File: rtl/snd_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module  : snd_cmd_fifo
// Brief   : Small synchronous register FIFO with push/pop/full/empty/count.
//           Pushes when full and pops when empty are ignored.
// Revision: 1.0 - initial release
// ============================================================================
module snd_cmd_fifo #(
    parameter int DEPTH_LOG2 = 2,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_din,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_dout,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  w_push;
    logic                  w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap modulo depth; simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule : snd_cmd_fifo
`default_nettype wire

// File: rtl/snd_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module  : snd_cmd_tx
// Brief   : Main-CPU-side sound command transmitter. Queues command bytes and
//           hands them one at a time to the sound board latch, pacing on the
//           board's ms (busy) flag.
// Revision: 1.0 - initial release
// ============================================================================
module snd_cmd_tx
    import snd_pkg::*;
#(
    parameter int DEPTH_LOG2  = 2,
    parameter int SETUP_CYC   = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_cpu_wr,
    input  logic [7:0] i_cpu_din,
    input  logic       i_cpu_rd_st,
    output logic [7:0] o_status_dout,
    input  logic       i_ms,
    input  logic       i_pause,
    output logic [7:0] o_data_out,
    output logic       o_mcode
);

    localparam int CW = DEPTH_LOG2 + 1;

    snd_tx_st_t  r_state;
    snd_tx_st_t  w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [7:0]  r_data;
    logic        r_ovf;
    logic        r_lost;
    logic        r_ms_s1;
    logic        r_ms_sync;
    logic        w_pop;
    logic        w_lost_set;
    logic        w_ovf_set;
    logic        w_strobe;
    logic        w_full;
    logic        w_empty;
    logic [CW-1:0] w_count;
    logic [7:0]  w_fifo_dout;

    snd_cmd_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (i_cpu_wr),
        .i_din   (i_cpu_din),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_ovf_set = i_cpu_wr & w_full;

    // Two-flop synchroniser for the asynchronous sound-board busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ms_s1   <= 1'b0;
            r_ms_sync <= 1'b0;
        end else begin
            r_ms_s1   <= i_ms;
            r_ms_sync <= r_ms_s1;
        end
    end

    // State, shared setup/timeout counter and output latch registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_data  <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_pop) begin
                r_data <= w_fifo_dout;
            end
        end
    end

    // Next-state logic; pause freezes everything, deferring a pending strobe
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        w_lost_set  = 1'b0;
        w_strobe    = 1'b0;
        if (!i_pause) begin
            case (r_state)
                IDLE: begin
                    if (!w_empty && !r_ms_sync) begin
                        w_pop       = 1'b1;
                        w_cnt_nxt   = 16'(SETUP_CYC);
                        w_state_nxt = SETUP;
                    end
                end
                SETUP: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = STROBE;
                    end else begin
                        w_cnt_nxt = r_cnt - 16'd1;
                    end
                end
                STROBE: begin
                    w_strobe    = 1'b1;
                    w_cnt_nxt   = 16'(TIMEOUT_CYC);
                    w_state_nxt = WAIT_SET;
                end
                WAIT_SET: begin
                    if (r_ms_sync) begin
                        w_state_nxt = WAIT_CLR;
                    end else if (r_cnt == '0) begin
                        w_lost_set  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 16'd1;
                    end
                end
                WAIT_CLR: begin
                    // The sound CPU may take arbitrarily long to ack
                    if (!r_ms_sync) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Sticky error flags: a status read clears them, a same-cycle new event wins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf  <= 1'b0;
            r_lost <= 1'b0;
        end else begin
            r_ovf  <= w_ovf_set  | (r_ovf  & ~i_cpu_rd_st);
            r_lost <= w_lost_set | (r_lost & ~i_cpu_rd_st);
        end
    end

    // Status byte assembled combinationally so a read sees it the same cycle
    always_comb begin
        o_status_dout                             = 8'h00;
        o_status_dout[STAT_OVF]                   = r_ovf;
        o_status_dout[STAT_LOST]                  = r_lost;
        o_status_dout[STAT_MS]                    = r_ms_sync;
        o_status_dout[STAT_BUSY]                  = (r_state != IDLE);
        o_status_dout[STAT_CNT_MSB:STAT_CNT_LSB]  = sat3(32'(w_count));
    end

    // Reset suppresses the strobe at once so no partial pulse leaves the block
    assign o_mcode    = w_strobe & ~rst;
    assign o_data_out = r_data;

endmodule : snd_cmd_tx
`default_nettype wire

// File: tb/tb_snd_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_snd_cmd_tx
// Brief   : Self-checking bench for snd_cmd_tx with a sound-board model and a
//           queue-based reference of the command delivery timeline.
// Revision: 1.0 - initial release
// ============================================================================
module tb_snd_cmd_tx;

    localparam int DEPTH_LOG2  = 2;
    localparam int DEPTH       = 4;
    localparam int SETUP_CYC   = 4;
    localparam int TIMEOUT_CYC = 200;

    // Reference delivery phases
    localparam int M_FREE    = 0;
    localparam int M_HOLD    = 1;
    localparam int M_FIRE    = 2;
    localparam int M_AWAIT   = 3;
    localparam int M_RELEASE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_cpu_wr = 1'b0;
    logic [7:0] i_cpu_din = 8'h00;
    logic       i_cpu_rd_st = 1'b0;
    logic [7:0] o_status_dout;
    logic       i_ms = 1'b0;
    logic       i_pause = 1'b0;
    logic [7:0] o_data_out;
    logic       o_mcode;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Board model controls (written only by the main stimulus process)
    bit force_ms  = 1'b0;
    bit board_en  = 1'b1;
    bit board_rnd = 1'b0;
    int ack_dly   = 20;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] seen[$];
    bit         m_ovf, m_lost, m_ms1, m_ms_sync;
    int         m_phase, m_left;
    logic [7:0] m_data;

    always #5 clk = ~clk;

    snd_cmd_tx #(
        .DEPTH_LOG2  (DEPTH_LOG2),
        .SETUP_CYC   (SETUP_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_cpu_wr      (i_cpu_wr),
        .i_cpu_din     (i_cpu_din),
        .i_cpu_rd_st   (i_cpu_rd_st),
        .o_status_dout (o_status_dout),
        .i_ms          (i_ms),
        .i_pause       (i_pause),
        .o_data_out    (o_data_out),
        .o_mcode       (o_mcode)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: each queued byte is popped when the link is free and the
    // board is not busy, held for SETUP_CYC+1 unpaused cycles, strobed once,
    // then the link waits for the board to raise and drop ms (or times out).
    always @(posedge clk) begin : ref_model
        bit ovf_set;
        bit lost_set;
        if (rst) begin
            q.delete();
            m_ovf = 0; m_lost = 0; m_ms1 = 0; m_ms_sync = 0;
            m_phase = M_FREE; m_left = 0; m_data = 8'h00;
        end else begin
            ovf_set  = i_cpu_wr && (q.size() == DEPTH);
            lost_set = 0;
            if (!i_pause) begin
                if (m_phase == M_FREE) begin
                    if (q.size() > 0 && !m_ms_sync) begin
                        m_data  = q.pop_front();
                        m_left  = SETUP_CYC + 1;
                        m_phase = M_HOLD;
                    end
                end else if (m_phase == M_HOLD) begin
                    m_left--;
                    if (m_left == 0) m_phase = M_FIRE;
                end else if (m_phase == M_FIRE) begin
                    m_left  = TIMEOUT_CYC + 1;
                    m_phase = M_AWAIT;
                end else if (m_phase == M_AWAIT) begin
                    m_left--;
                    if (m_ms_sync) m_phase = M_RELEASE;
                    else if (m_left == 0) begin
                        lost_set = 1;
                        m_phase  = M_FREE;
                    end
                end else begin
                    if (!m_ms_sync) m_phase = M_FREE;
                end
            end
            if (i_cpu_wr && !ovf_set) q.push_back(i_cpu_din);
            m_ovf     = ovf_set  || (m_ovf  && !i_cpu_rd_st);
            m_lost    = lost_set || (m_lost && !i_cpu_rd_st);
            m_ms_sync = m_ms1;
            m_ms1     = i_ms;
        end
    end

    // Continuous comparison of all outputs against the reference
    always @(negedge clk) begin
        logic [7:0] exp_st;
        int         n;
        if (chk_en) begin
            n      = (q.size() > 7) ? 7 : q.size();
            exp_st = {m_ovf, m_lost, m_ms_sync, (m_phase != M_FREE), 1'b0, 3'(n)};
            check("mcode",  16'(o_mcode), 16'((m_phase == M_FIRE) && !i_pause && !rst));
            check("data",   16'(o_data_out), 16'(m_data));
            check("status", 16'(o_status_dout), 16'(exp_st));
            if (o_mcode) seen.push_back(o_data_out);
        end
    end

    // Sound board: raises ms a short delay after each strobe, drops it
    // (the ack) after a configurable hold; may ignore a strobe entirely.
    initial begin : board
        bit mc;
        int set_cnt, clr_cnt, ack, b_ms;
        set_cnt = 0; clr_cnt = 0; ack = 0; b_ms = 0;
        forever begin
            @(negedge clk);
            mc = o_mcode;
            @(posedge clk);
            #2;
            if (rst) begin
                set_cnt = 0; clr_cnt = 0; b_ms = 0;
            end else begin
                if (mc && board_en && !(board_rnd && $urandom_range(0, 7) == 0)) begin
                    set_cnt = board_rnd ? $urandom_range(1, 6) : 2;
                    ack     = board_rnd ? $urandom_range(1, 40) : ack_dly;
                end
                if (set_cnt > 0) begin
                    set_cnt--;
                    if (set_cnt == 0) begin
                        b_ms    = 1;
                        clr_cnt = ack;
                    end
                end else if (b_ms != 0) begin
                    if (clr_cnt > 0) clr_cnt--;
                    if (clr_cnt == 0) b_ms = 0;
                end
            end
            i_ms = (b_ms != 0) || force_ms;
        end
    end

    task automatic cpu_write(input logic [7:0] b);
        i_cpu_wr  = 1'b1;
        i_cpu_din = b;
        @(posedge clk); #1;
        i_cpu_wr  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Count negedges from now until mcode is seen; bounded
    task automatic wait_mcode(input string tag, input int max, output int lat);
        lat = 0;
        while (lat < max) begin
            @(negedge clk);
            if (o_mcode) break;
            lat++;
        end
        if (lat >= max) check({tag, "_timeout"}, 16'(lat), 16'(max - 1));
        @(posedge clk); #1;
    endtask

    initial begin : stim
        int lat, pulses, base;
        @(posedge clk); #1;
        chk_en = 1'b1;
        idle_cycles(2);
        rst = 1'b0;
        @(negedge clk);
        check("rst_status", 16'(o_status_dout), 16'h0000);
        check("rst_data",   16'(o_data_out),    16'h0000);
        @(posedge clk); #1;

        // 1: single command latency and board handshake
        ack_dly = 20;
        cpu_write(8'h5A);
        lat = 1;
        while (lat < 40) begin
            @(negedge clk);
            if (o_mcode) break;
            lat++;
        end
        check("t1_latency", 16'(lat), 16'(1 + 1 + SETUP_CYC + 1));
        check("t1_byte",    16'(o_data_out), 16'h005A);
        @(posedge clk); #1;
        idle_cycles(8);
        check("t1_busy_wclr", 16'(o_status_dout[4]), 16'h0001);
        idle_cycles(30);

        // 2: three back-to-back commands, slow ack
        ack_dly = 100;
        base = seen.size();
        cpu_write(8'h01);
        cpu_write(8'h02);
        cpu_write(8'h03);
        idle_cycles(450);
        check("t2_npulse", 16'(seen.size() - base), 16'd3);
        if (seen.size() - base == 3) begin
            check("t2_b0", 16'(seen[base]),     16'h0001);
            check("t2_b1", 16'(seen[base + 1]), 16'h0002);
            check("t2_b2", 16'(seen[base + 2]), 16'h0003);
        end

        // 3: board held busy, overflow on the fifth write
        force_ms = 1'b1;
        idle_cycles(3);
        for (int i = 0; i < 5; i++) cpu_write(8'h10 + 8'(i));
        @(negedge clk);
        check("t3_status", 16'(o_status_dout), 16'h00A4);
        @(posedge clk); #1;
        i_cpu_rd_st = 1'b1;
        @(negedge clk);
        check("t3_rd_same", 16'(o_status_dout[7]), 16'h0001);
        @(posedge clk); #1;
        i_cpu_rd_st = 1'b0;
        @(negedge clk);
        check("t3_ovf_clr", 16'(o_status_dout[7]), 16'h0000);
        @(posedge clk); #1;
        force_ms = 1'b0;
        ack_dly  = 5;
        idle_cycles(120);

        // 4: board never answers, lost flag then the next byte goes out
        board_en = 1'b0;
        cpu_write(8'hC1);
        cpu_write(8'hC2);
        idle_cycles(SETUP_CYC + TIMEOUT_CYC + 8);
        check("t4_lost", 16'(o_status_dout[6]), 16'h0001);
        idle_cycles(TIMEOUT_CYC + 20);
        i_cpu_rd_st = 1'b1;
        idle_cycles(1);
        i_cpu_rd_st = 1'b0;
        board_en = 1'b1;
        ack_dly  = 10;
        idle_cycles(5);

        // 5: pause during setup
        cpu_write(8'h77);
        idle_cycles(2);
        i_pause = 1'b1;
        pulses = 0;
        repeat (50) begin
            @(negedge clk);
            if (o_mcode) pulses++;
            @(posedge clk); #1;
        end
        check("t5_paused_pulses", 16'(pulses), 16'd0);
        i_pause = 1'b0;
        wait_mcode("t5", 40, lat);
        check("t5_resume_lat", 16'(lat), 16'(SETUP_CYC + 1 - 1));
        idle_cycles(40);

        // 6: reset in WAIT_SET with two bytes queued
        board_en = 1'b0;
        cpu_write(8'hE1);
        cpu_write(8'hE2);
        cpu_write(8'hE3);
        wait_mcode("t6", 40, lat);
        idle_cycles(2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_status", 16'(o_status_dout), 16'h0000);
        check("t6_mcode",  16'(o_mcode), 16'h0000);
        @(posedge clk); #1;
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (o_mcode) pulses++;
            @(posedge clk); #1;
        end
        check("t6_no_pulse", 16'(pulses), 16'd0);

        // Randomized traffic against the reference
        board_en  = 1'b1;
        board_rnd = 1'b1;
        repeat (3000) begin
            i_cpu_wr    = ($urandom_range(0, 3) == 0);
            i_cpu_din   = 8'($urandom);
            i_cpu_rd_st = ($urandom_range(0, 15) == 0);
            if (i_pause) i_pause = ($urandom_range(0, 3) != 0);
            else         i_pause = ($urandom_range(0, 29) == 0);
            @(posedge clk); #1;
        end
        i_cpu_wr = 1'b0; i_cpu_rd_st = 1'b0; i_pause = 1'b0;
        idle_cycles(300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_snd_cmd_tx
`default_nettype wire
